// File: rtl/fifo_drain_pkg.sv
// Shared types and defaults for the FIFO drain controller and its skid buffer.
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry skid buffer: head register feeds the consumer, tail absorbs one word of backpressure.
module fifo_drain_skid
    import fifo_drain_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [width-1:0] i_data,
    input  logic             i_ready,
    output logic [width-1:0] o_data,
    output logic             o_valid,
    output logic [1:0]       o_occupancy,
    output state_t           o_state
);

    state_t           r_state;
    logic [width-1:0] r_head;
    logic [width-1:0] r_tail;
    logic             r_valid;
    logic [1:0]       r_occ;
    logic             w_xfer;

    assign w_xfer = r_valid & i_ready;

    // NOTE: non-blocking assignments so every register samples pre-edge values of its peers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
            r_occ   <= 2'd0;
            // NOTE: data words are reset too, so out_data reads zero rather than stale data after reset.
            r_head  <= '0;
            r_tail  <= '0;
        end else if (i_flush) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
            r_occ   <= 2'd0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (i_push) begin
                        r_head  <= i_data;
                        r_state <= ONE;
                        r_valid <= 1'b1;
                        r_occ   <= 2'd1;
                    end
                end
                ONE: begin
                    if (i_push && w_xfer) begin
                        r_head <= i_data;
                    end else if (i_push) begin
                        r_tail  <= i_data;
                        r_state <= TWO;
                        r_occ   <= 2'd2;
                    end else if (w_xfer) begin
                        r_state <= EMPTY;
                        r_valid <= 1'b0;
                        r_occ   <= 2'd0;
                    end
                end
                TWO: begin
                    if (w_xfer) begin
                        r_head  <= r_tail;
                        r_state <= ONE;
                        r_occ   <= 2'd1;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_valid <= 1'b0;
                    r_occ   <= 2'd0;
                end
            endcase
        end
    end

    assign o_data      = r_head;
    assign o_valid     = r_valid;
    assign o_occupancy = r_occ;
    assign o_state     = r_state;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains a first-word-fall-through FIFO into a ready/valid stream through a 2-entry skid buffer.
// Optional delivered-word counter (word_cnt port) is enabled by defining FIFO_DRAIN_CNT_EN.
module fifo_drain_ctrl
    import fifo_drain_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH,
    parameter int cnt_w = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] fifo_dout,
    input  logic             fifo_pndng,
    output logic             fifo_pop,
    input  logic             flush,
    output logic [width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       occupancy
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [cnt_w-1:0] word_cnt
`endif
);

    if (width < 1 || cnt_w < 1) begin : g_bad_param
        $error("fifo_drain_ctrl: width and cnt_w must both be at least 1");
    end

    state_t w_state;
    logic   w_pop;

    // Pop never looks at out_ready; the tail slot absorbs a stalled consumer.
    assign w_pop    = rst & fifo_pndng & ~flush & (w_state != TWO);
    assign fifo_pop = w_pop;

    fifo_drain_skid #(
        .width(width)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (flush),
        .i_push     (w_pop),
        .i_data     (fifo_dout),
        .i_ready    (out_ready),
        .o_data     (out_data),
        .o_valid    (out_valid),
        .o_occupancy(occupancy),
        .o_state    (w_state)
    );

`ifdef FIFO_DRAIN_CNT_EN
    logic [cnt_w-1:0] r_word_cnt;
    logic             w_xfer;

    // A transfer coinciding with flush is discarded, so it is not counted.
    assign w_xfer = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_cnt <= '0;
        end else if (w_xfer) begin
            r_word_cnt <= r_word_cnt + 1'b1;
        end
    end

    assign word_cnt = r_word_cnt;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl: queue-based upstream FIFO and skid-buffer reference model.
module tb_fifo_drain_ctrl;

    localparam int W = 16;
`ifdef FIFO_DRAIN_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  fifo_dout = '0;
    logic          fifo_pndng = 1'b0;
    logic          fifo_pop;
    logic          flush = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    occupancy;
`ifdef FIFO_DRAIN_CNT_EN
    logic [CW-1:0] word_cnt;
`endif

    fifo_drain_ctrl #(
        .width(W),
        .cnt_w(CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_dout (fifo_dout),
        .fifo_pndng(fifo_pndng),
        .fifo_pop  (fifo_pop),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
`ifdef FIFO_DRAIN_CNT_EN
        ,
        .word_cnt  (word_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] up_q[$];
    logic [W-1:0] exp_q[$];
    int cnt_model = 0;
    int delivered = 0;

    // One clock cycle, entered and left on a negedge. The reference model is the
    // queue of words taken from the FIFO but not yet accepted downstream.
    task automatic step(input bit rdy, input bit pnd_en, input bit fl);
        bit           exp_pop;
        bit           dut_pop;
        bit           xfer;
        logic [W-1:0] head;
        out_ready  = rdy;
        flush      = fl;
        fifo_pndng = pnd_en && (up_q.size() > 0);
        fifo_dout  = fifo_pndng ? up_q[0] : '0;
        #1;
        exp_pop = fifo_pndng && !fl && (exp_q.size() < 2);
        n_cmp++;
        if (fifo_pop !== exp_pop) begin
            n_bad++;
            $display("FAIL fifo_pop @%0t: got %b want %b", $time, fifo_pop, exp_pop);
        end
        n_cmp++;
        if (out_valid !== (exp_q.size() > 0)) begin
            n_bad++;
            $display("FAIL out_valid @%0t: got %b want %b", $time, out_valid, exp_q.size() > 0);
        end
        n_cmp++;
        if (occupancy !== 2'(exp_q.size())) begin
            n_bad++;
            $display("FAIL occupancy @%0t: got %0d want %0d", $time, occupancy, exp_q.size());
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            if (out_data !== exp_q[0]) begin
                n_bad++;
                $display("FAIL out_data @%0t: got %h want %h", $time, out_data, exp_q[0]);
            end
        end
`ifdef FIFO_DRAIN_CNT_EN
        n_cmp++;
        if (word_cnt !== CW'(cnt_model)) begin
            n_bad++;
            $display("FAIL word_cnt @%0t: got %0d want %0d", $time, word_cnt, cnt_model);
        end
`endif
        dut_pop = (fifo_pop === 1'b1);
        xfer    = (exp_q.size() > 0) && rdy && !fl;
        head    = fifo_dout;
        @(posedge clk);
        if (dut_pop) void'(up_q.pop_front());
        if (fl) begin
            exp_q.delete();
        end else begin
            if (xfer) begin
                void'(exp_q.pop_front());
                delivered++;
                cnt_model = (cnt_model + 1) % (1 << CW);
            end
            if (exp_pop) exp_q.push_back(head);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        fifo_pndng = 1'b0;
        fifo_dout  = '0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        up_q.delete();
        exp_q.delete();
        cnt_model = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        fifo_pndng = 1'b1;
        fifo_dout  = 16'h1234;
        out_ready  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (fifo_pop !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_pop: got %b want 0", fifo_pop);
            end
            n_cmp++;
            if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
                n_bad++;
                $display("FAIL reset_state: valid %b occ %0d want 0/0", out_valid, occupancy);
            end
            n_cmp++;
            if (out_data !== '0) begin
                n_bad++;
                $display("FAIL reset_data: got %h want 0000", out_data);
            end
`ifdef FIFO_DRAIN_CNT_EN
            n_cmp++;
            if (word_cnt !== '0) begin
                n_bad++;
                $display("FAIL reset_cnt: got %0d want 0", word_cnt);
            end
`endif
        end
        do_reset();
    endtask

    task automatic test_stream();
        int d0;
        do_reset();
        for (int i = 1; i <= 4; i++) up_q.push_back(W'(i));
        d0 = delivered;
        repeat (6) step(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (delivered - d0 != 4) begin
            n_bad++;
            $display("FAIL stream_count: got %0d want 4", delivered - d0);
        end
    endtask

    task automatic test_backpressure();
        int d0;
        do_reset();
        up_q.push_back(16'hAAAA);
        up_q.push_back(16'hBBBB);
        up_q.push_back(16'hCCCC);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (up_q.size() != 1) begin
            n_bad++;
            $display("FAIL bp_pops: fifo left %0d words want 1", up_q.size());
        end
        d0 = delivered;
        repeat (5) step(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (delivered - d0 != 3 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL bp_drain: delivered %0d buffered %0d want 3/0", delivered - d0, exp_q.size());
        end
    endtask

    task automatic test_flush();
        do_reset();
        up_q.push_back(16'h0011);
        up_q.push_back(16'h0022);
        up_q.push_back(16'h0033);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (up_q.size() != 1 || up_q[0] !== 16'h0033) begin
            n_bad++;
            $display("FAIL flush_fifo: fifo has %0d words want 1 (0033)", up_q.size());
        end
        repeat (3) step(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        do_reset();
        up_q.push_back(16'h0005);
        up_q.push_back(16'h0006);
        step(1'b0, 1'b1, 1'b0);
        fifo_pndng = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_bad++;
            $display("FAIL async_reset: valid %b occ %0d want 0/0", out_valid, occupancy);
        end
        exp_q.delete();
        cnt_model = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (up_q.size() != 0) begin
            n_bad++;
            $display("FAIL async_resume: fifo left %0d words want 0", up_q.size());
        end
    endtask

`ifdef FIFO_DRAIN_CNT_EN
    task automatic test_counter();
        int d0;
        int cyc;
        do_reset();
        for (int i = 0; i < 17; i++) up_q.push_back(W'(16'h0100 + i));
        d0  = delivered;
        cyc = 0;
        while (delivered - d0 < 17 && cyc < 40) begin
            step(1'b1, 1'b1, 1'b0);
            cyc++;
        end
        n_cmp++;
        if (word_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL cnt_wrap: got %0d want 1", word_cnt);
        end
        up_q.push_back(16'h0200);
        up_q.push_back(16'h0201);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (word_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL cnt_flush: got %0d want 1", word_cnt);
        end
    endtask
`endif

    task automatic test_random();
        int d0;
        int sent;
        int cyc;
        do_reset();
        d0   = delivered;
        sent = 0;
        cyc  = 0;
        while (delivered - d0 < 10000 && cyc < 60000) begin
            while (up_q.size() < 4 && sent < 10000) begin
                up_q.push_back(W'(sent));
                sent++;
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b0);
            cyc++;
        end
        n_cmp++;
        if (delivered - d0 != 10000 || exp_q.size() != 0 || up_q.size() != 0) begin
            n_bad++;
            $display("FAIL random_total: delivered %0d buffered %0d fifo %0d want 10000/0/0",
                     delivered - d0, exp_q.size(), up_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef FIFO_DRAIN_CNT_EN
        test_counter();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
